// File: rtl/mem_arbiter_2p_if.sv
// rtl/mem_arbiter_2p_if.sv - requester and memory bus bundle for mem_arbiter_2p
//
// Purpose: groups both requester ports, the status outputs and the
// memory-side signals of mem_arbiter_2p into one interface.
// Ports (signals):
//   req0/we0/addr0/wdata0 -> ack0/rdata0   port 0 command and completion
//   req1/we1/addr1/wdata1 -> ack1/rdata1   port 1 command and completion
//   busy, gnt_id                           arbiter status
//   mem_address/mem_data_in/mem_read_en/mem_write_en -> memory
//   mem_data_out                           <- memory
// Modports: slave = arbiter side, master = requesters plus memory side.

interface mem_arbiter_2p_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              busy;
  logic              gnt_id;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_data_out,
    output ack0, rdata0, ack1, rdata1,
    output busy, gnt_id,
    output mem_address, mem_data_in, mem_read_en, mem_write_en
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_data_out,
    input  ack0, rdata0, ack1, rdata1,
    input  busy, gnt_id,
    input  mem_address, mem_data_in, mem_read_en, mem_write_en
  );
endinterface

// File: rtl/mem_arbiter_2p.sv
// rtl/mem_arbiter_2p.sv - two-port round-robin arbiter/sequencer for a single-port memory
//
// Purpose: serialises read/write commands from two requesters onto one
// single-port memory and returns a one-cycle ack (plus read data) per command.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_2p_if.slave: requester ports 0/1, busy/gnt_id status,
//          memory address/data_in/read_en/write_en/data_out
// Parameters: ADDR_W, DATA_W widths; RD_LAT (1..7) memory read latency.

module mem_arbiter_2p #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_2p_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, ACK} state_t;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;      // port preferred when both request
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic pick;
  logic busy;
  logic rd_en, wr_en, ack0, ack1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    // With a single request the pointer is irrelevant; with both it decides.
    pick     = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          wr_en   = 1'b1;
          state_d = ACK;
        end else begin
          rd_en   = 1'b1;
          cnt_d   = RD_LAT_C;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        // cnt_q == 1 marks the RD_LAT-th cycle after ISSUE: data is valid now.
        if (cnt_q == 3'd1) begin
          if (gnt_q) rdata1_d = bus.mem_data_out;
          else       rdata0_d = bus.mem_data_out;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ACK: begin
        ack0    = ~gnt_q;
        ack1    = gnt_q;
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy             = (state_q != IDLE);
  assign bus.busy         = busy;
  assign bus.gnt_id       = busy & gnt_q;
  assign bus.mem_address  = busy ? addr_q  : '0;
  assign bus.mem_data_in  = busy ? wdata_q : '0;
  assign bus.mem_read_en  = rd_en;
  assign bus.mem_write_en = wr_en;
  assign bus.ack0         = ack0;
  assign bus.ack1         = ack1;
  assign bus.rdata0       = rdata0_q;
  assign bus.rdata1       = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb/tb_mem_arbiter_2p.sv - randomized self-checking bench for mem_arbiter_2p

module tb_mem_arbiter_2p;

  localparam int RD_LAT   = 1;
  localparam int RD_LAT_B = 3;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  logic clk;
  logic rst;

  mem_arbiter_2p_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  mem_arbiter_2p_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

  mem_arbiter_2p #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mem_arbiter_2p #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory for dut_a: data is valid only in the RD_LAT-th cycle after the
  // read enable; every other cycle shows random junk.
  logic [7:0] mem [256];
  logic [7:0] pipe_d [RD_LAT];
  always @(posedge clk) begin
    pipe_d[0] <= bus_a.mem_read_en ? mem[bus_a.mem_address] : 8'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
    if (bus_a.mem_write_en) mem[bus_a.mem_address] <= bus_a.mem_data_in;
  end
  assign bus_a.mem_data_out = pipe_d[RD_LAT-1];

  // Memory for dut_b: data_out = C0 + cycles since the read enable.
  logic [7:0] cnt_b;
  always @(posedge clk) cnt_b <= bus_b.mem_read_en ? 8'd1 : cnt_b + 8'd1;
  assign bus_b.mem_data_out = 8'hC0 + cnt_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state (transaction level).
  logic       m_busy;
  logic       m_port;
  logic       m_we;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  int         m_start;
  int         m_dur;
  logic       m_ptr;
  logic [7:0] rdata_exp [2];
  logic [7:0] ref_mem [256];
  int         grants [$];

  // Requester state.
  cmd_t pq [2][$];
  cmd_t cur [2];
  bit   act [2];
  logic req_v [2];
  bit   rnd_mode = 0;

  task automatic drive_ports();
    bus_a.req0 = req_v[0]; bus_a.we0 = cur[0].we; bus_a.addr0 = cur[0].addr; bus_a.wdata0 = cur[0].wdata;
    bus_a.req1 = req_v[1]; bus_a.we1 = cur[1].we; bus_a.addr1 = cur[1].addr; bus_a.wdata1 = cur[1].wdata;
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_port = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    m_start = 0; m_dur = 0;
    for (int p = 0; p < 2; p++) begin
      rdata_exp[p] = 8'h00; act[p] = 0; req_v[p] = 0; cur[p] = '0; pq[p].delete();
    end
    drive_ports();
  endtask

  task automatic step();
    logic       e_busy, e_gnt, e_ren, e_wen, e_ack0, e_ack1;
    logic [7:0] e_addr, e_din;
    bit         was_free, acked;
    int         d;
    logic       port;
    @(negedge clk);
    cyc++;
    e_busy = 0; e_gnt = 0; e_ren = 0; e_wen = 0; e_ack0 = 0; e_ack1 = 0;
    e_addr = 0; e_din = 0;
    was_free = !m_busy;
    acked = 0;
    if (m_busy) begin
      d = cyc - m_start;
      e_busy = 1; e_gnt = m_port; e_addr = m_addr; e_din = m_wdata;
      if (d == 1) begin
        e_wen = m_we; e_ren = !m_we;
        if (m_we) ref_mem[m_addr] = m_wdata;
      end
      if (d == m_dur) begin
        acked = 1;
        if (m_port) e_ack1 = 1; else e_ack0 = 1;
        if (!m_we) rdata_exp[m_port] = ref_mem[m_addr];
      end
    end
    chk("busy",     bus_a.busy,         e_busy);
    chk("gnt_id",   bus_a.gnt_id,       e_gnt);
    chk("mem_addr", bus_a.mem_address,  e_addr);
    chk("mem_din",  bus_a.mem_data_in,  e_din);
    chk("read_en",  bus_a.mem_read_en,  e_ren);
    chk("write_en", bus_a.mem_write_en, e_wen);
    chk("ack0",     bus_a.ack0,         e_ack0);
    chk("ack1",     bus_a.ack1,         e_ack1);
    chk("rdata0",   bus_a.rdata0,       rdata_exp[0]);
    chk("rdata1",   bus_a.rdata1,       rdata_exp[1]);

    if (acked) begin
      m_busy = 0;
      m_ptr = !m_port;
      act[m_port] = 0;
    end

    for (int p = 0; p < 2; p++) begin
      if (!act[p]) begin
        req_v[p] = 0;
        if (pq[p].size() > 0) begin
          cur[p] = pq[p].pop_front(); act[p] = 1; req_v[p] = 1;
        end else if (rnd_mode && $urandom_range(0, 3) == 0) begin
          cur[p].we = 1'($urandom_range(0, 1));
          cur[p].addr = 8'($urandom_range(0, 15));
          cur[p].wdata = 8'($urandom);
          act[p] = 1; req_v[p] = 1;
        end
      end else if (rnd_mode && m_busy && m_port == 1'(p) && $urandom_range(0, 3) == 0) begin
        req_v[p] = 0;   // already granted: dropping req must not cancel it
      end
    end
    drive_ports();

    if (was_free && (req_v[0] || req_v[1])) begin
      if (req_v[0] && req_v[1]) port = m_ptr;
      else port = req_v[1];
      m_busy = 1; m_port = port;
      m_we = cur[port].we; m_addr = cur[port].addr; m_wdata = cur[port].wdata;
      m_start = cyc;
      m_dur = m_we ? 2 : 2 + RD_LAT;
      grants.push_back(int'(port));
    end
  endtask

  task automatic run_until_idle(input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      step();
      done = !m_busy && !act[0] && !act[1] && pq[0].size() == 0 && pq[1].size() == 0;
    end
    chk("drain_done", 32'(done), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gidx;
    int ack_at, ren_at;
    logic [7:0] w;
    bit hit;

    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    bus_b.req0 = 0; bus_b.we0 = 0; bus_b.addr0 = 0; bus_b.wdata0 = 0;
    bus_b.req1 = 0; bus_b.we1 = 0; bus_b.addr1 = 0; bus_b.wdata1 = 0;
    model_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Idle after reset.
    repeat (20) step();

    // Single write, single read, then contention.
    pq[0].push_back('{1'b1, 8'h01, 8'h55});
    run_until_idle(50);
    pq[1].push_back('{1'b0, 8'h01, 8'h00});
    run_until_idle(50);
    chk("dir_rdata1", bus_a.rdata1, 8'h55);
    chk("dir_rdata0_kept", bus_a.rdata0, 8'h00);

    gidx = grants.size();
    pq[0].push_back('{1'b1, 8'h10, 8'hAA});
    pq[1].push_back('{1'b1, 8'h11, 8'hBB});
    pq[0].push_back('{1'b0, 8'h10, 8'h00});
    pq[1].push_back('{1'b0, 8'h11, 8'h00});
    run_until_idle(100);
    chk("grant_count", grants.size() - gidx, 4);
    for (int i = 0; i < 4 && gidx + i < grants.size(); i++)
      chk($sformatf("grant_order%0d", i), grants[gidx+i], i % 2);
    chk("cont_rdata0", bus_a.rdata0, 8'hAA);
    chk("cont_rdata1", bus_a.rdata1, 8'hBB);

    // Reset while a read sits in its wait phase.
    pq[0].push_back('{1'b0, 8'h10, 8'h00});
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = m_busy && !m_we && (cyc - m_start >= 2);
    end
    chk("reached_rwait", 32'(hit), 1);
    #2 rst = 1;
    #1;
    chk("rst_busy",  bus_a.busy,         0);
    chk("rst_ren",   bus_a.mem_read_en,  0);
    chk("rst_wen",   bus_a.mem_write_en, 0);
    chk("rst_addr",  bus_a.mem_address,  0);
    chk("rst_din",   bus_a.mem_data_in,  0);
    chk("rst_ack0",  bus_a.ack0,         0);
    chk("rst_ack1",  bus_a.ack1,         0);
    chk("rst_gnt",   bus_a.gnt_id,       0);
    chk("rst_rd0",   bus_a.rdata0,       0);
    chk("rst_rd1",   bus_a.rdata1,       0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 chk("rst_hold_ack0", bus_a.ack0, 0);
    @(negedge clk);
    rst = 0;
    pq[0].push_back('{1'b0, 8'h10, 8'h00});
    run_until_idle(50);
    chk("post_rst_rdata0", bus_a.rdata0, 8'hAA);

    // Fill low addresses, then random traffic from both ports.
    for (int a = 0; a < 16; a++) begin
      w = 8'($urandom);
      pq[a % 2].push_back('{1'b1, 8'(a), w});
    end
    run_until_idle(200);
    rnd_mode = 1;
    repeat (2000) step();
    rnd_mode = 0;
    run_until_idle(100);

    // Longer read latency instance.
    @(negedge clk);
    bus_b.req0 = 1; bus_b.we0 = 0; bus_b.addr0 = 8'h33; bus_b.wdata0 = 8'h00;
    ack_at = -1; ren_at = -1;
    for (int j = 1; j <= 20 && ack_at < 0; j++) begin
      @(negedge clk);
      if (bus_b.mem_read_en && ren_at < 0) ren_at = j;
      chk("b_ack1", bus_b.ack1, 0);
      if (bus_b.ack0) begin
        ack_at = j;
        bus_b.req0 = 0;
      end
    end
    chk("b_ren_cycle", ren_at, 1);
    chk("b_ack_cycle", ack_at, 2 + RD_LAT_B);
    chk("b_rdata0", bus_b.rdata0, 8'hC0 + 8'(RD_LAT_B));
    @(negedge clk);
    chk("b_idle_busy", bus_b.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
